// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous memory between instruction-fetch (IF) and data (DM) ports.
// Define ARB_STARVE_GUARD_EN to force an IF grant after STARVE_LIMIT back-to-back DM wins; default is strict DM priority.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("MEM_LATENCY must be in 1..15");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
        $error("STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_LATENCY - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] wait_cnt;
    logic       grant_dm;
    logic       pick_dm;
    logic       pick_if;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt;

    // Counts DM wins that left a waiting IF behind; any other arbitration clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick_dm && if_req) begin
                starve_cnt <= starve_cnt + 4'd1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end
`endif

    always_comb begin
        pick_dm = dm_req;
        pick_if = if_req && !dm_req;
`ifdef ARB_STARVE_GUARD_EN
        if (dm_req && if_req && starve_cnt == STARVE_MAX) begin
            pick_dm = 1'b0;
            pick_if = 1'b1;
        end
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_dm || pick_if) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (wait_cnt == 4'd0) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign mem_en = (state == ISSUE);
    assign busy   = (state != IDLE);
    assign if_ack = (state == ACK) && !grant_dm;
    assign dm_ack = (state == ACK) && grant_dm;

    // Memory-side fields are captured once at grant and held until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            grant_dm  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (pick_dm) begin
                        grant_dm  <= 1'b1;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_we    <= dm_we;
                    end else if (pick_if) begin
                        grant_dm  <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_we    <= 1'b0;
                    end
                end
                ISSUE: wait_cnt <= WAIT_INIT;
                WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (grant_dm) begin
                        dm_rdata <= mem_we ? '0 : mem_rdata;
                    end else begin
                        if_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model; honours ARB_STARVE_GUARD_EN the same way the design does.
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int MEM_LATENCY  = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int ACK_AGE      = MEM_LATENCY + 2;
    localparam int DONE_AGE     = MEM_LATENCY + 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req = 1'b0;
    logic              dm_we = 1'b0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [DATA_W-1:0] dm_wdata = '0;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(MEM_LATENCY), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_pulses = 0;
    int if_acks = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] seed_word(input int i);
        if (i == 16) return 32'hDEAD_BEEF;
        return 32'h5A5A_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0040;
            1:       return 32'h0000_0100;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_F3F8;
            4:       return 32'h0000_0080;
            5:       return 32'h0000_000C;
            6:       return 32'h0000_0200;
            default: return 32'h0000_02F0;
        endcase
    endfunction

    // Memory emulation: read data appears MEM_LATENCY cycles after the strobe, noise otherwise.
    logic [31:0] emu_mem [0:255];
    logic [31:0] rd_pipe [0:MEM_LATENCY-1];
    logic [31:0] rd_word;
    assign mem_rdata = rd_pipe[MEM_LATENCY-1];

    initial begin
        for (int i = 0; i < 256; i++) emu_mem[i] = seed_word(i);
        for (int i = 0; i < MEM_LATENCY; i++) rd_pipe[i] = '0;
        forever begin
            @(posedge clk);
            rd_word = $urandom;
            if (mem_en && mem_we) emu_mem[mem_addr[9:2]] = mem_wdata;
            else if (mem_en) rd_word = emu_mem[mem_addr[9:2]];
            rd_pipe[0] <= rd_word;
            for (int i = 1; i < MEM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    // Transaction-level reference: one access at a time, age 1 = strobe, ACK_AGE = ack.
    logic [31:0] ref_mem [0:255];
    bit          m_active = 0;
    bit          m_is_dm = 0;
    bit          m_we = 0;
    int          m_age = 0;
    int          m_cnt = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    bit          m_if_done = 0;
    bit          m_dm_done = 0;

    initial begin
        bit go_dm;
        bit go_if;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
        forever begin
            @(posedge clk or posedge rst);
            m_if_done = 0;
            m_dm_done = 0;
            if (rst) begin
                m_active = 0;
                m_age    = 0;
                m_cnt    = 0;
            end else if (m_active) begin
                m_age++;
                if (m_age == DONE_AGE) begin
                    m_active = 0;
                    if (m_is_dm) m_dm_done = 1;
                    else m_if_done = 1;
                end
            end else begin
                go_dm = dm_req;
                go_if = if_req && !dm_req;
`ifdef ARB_STARVE_GUARD_EN
                if (dm_req && if_req && m_cnt == STARVE_LIMIT) begin
                    go_dm = 0;
                    go_if = 1;
                end
                if (go_dm && if_req) m_cnt++;
                else m_cnt = 0;
`endif
                if (go_dm || go_if) begin
                    m_active = 1;
                    m_age    = 1;
                    m_is_dm  = go_dm;
                    m_addr   = go_dm ? dm_addr : if_addr;
                    m_we     = go_dm && dm_we;
                    m_wdata  = dm_wdata;
                    if (m_we) begin
                        ref_mem[m_addr[9:2]] = m_wdata;
                        m_rdata = '0;
                    end else begin
                        m_rdata = ref_mem[m_addr[9:2]];
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Every-cycle comparison of the DUT against the reference.
    initial forever begin
        @(negedge clk);
        if (mem_en) en_pulses++;
        if (if_ack) if_acks++;
        if (!rst) begin
            checkOutput("busy", 32'(busy), 32'(m_active));
            checkOutput("mem_en", 32'(mem_en), 32'(m_active && m_age == 1));
            checkOutput("if_ack", 32'(if_ack), 32'(m_active && !m_is_dm && m_age == ACK_AGE));
            checkOutput("dm_ack", 32'(dm_ack), 32'(m_active && m_is_dm && m_age == ACK_AGE));
            if (m_active) begin
                checkOutput("mem_addr", mem_addr, m_addr);
                checkOutput("mem_we", 32'(mem_we), 32'(m_we));
                if (m_we) checkOutput("mem_wdata", mem_wdata, m_wdata);
                if (m_age == ACK_AGE && m_is_dm) checkOutput("dm_rdata", dm_rdata, m_rdata);
                if (m_age == ACK_AGE && !m_is_dm) checkOutput("if_rdata", if_rdata, m_rdata);
            end
        end
    end

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                 input logic dw, input logic [31:0] da, input logic [31:0] dd);
        if_req   = ir;
        if_addr  = ia;
        dm_req   = dr;
        dm_we    = dw;
        dm_addr  = da;
        dm_wdata = dd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitNeg(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    initial begin
        int c0;
        int e0;
        int a0;
        int got;
        logic [5:0] order_dm;
        logic [5:0] exp_order;
        bit if_pend;
        bit dm_pend;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst if_ack", 32'(if_ack), 32'd0);
        checkOutput("rst dm_ack", 32'(dm_ack), 32'd0);
        checkOutput("rst mem_en", 32'(mem_en), 32'd0);
        checkOutput("rst mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst mem_addr", mem_addr, 32'd0);
        checkOutput("rst mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst if_rdata", if_rdata, 32'd0);
        checkOutput("rst dm_rdata", dm_rdata, 32'd0);
        rst = 1'b0;
        repeat (2) nextCycle();

        // IF read of 0x40, held through ack and dropped on the ack edge.
        c0 = cyc; e0 = en_pulses; a0 = if_acks;
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        waitNeg(c0 + 1);
        checkOutput("ifrd mem_en c1", 32'(mem_en), 32'd1);
        checkOutput("ifrd mem_addr c1", mem_addr, 32'h40);
        waitNeg(c0 + 4);
        checkOutput("ifrd if_ack c4", 32'(if_ack), 32'd1);
        checkOutput("ifrd if_rdata c4", if_rdata, 32'hDEAD_BEEF);
        nextCycle();
        if_req = 1'b0;
        waitNeg(c0 + 5);
        checkOutput("ifrd busy c5", 32'(busy), 32'd0);
        waitNeg(c0 + 9);
        checkOutput("held req strobes", 32'(en_pulses - e0), 32'd1);
        checkOutput("held req acks", 32'(if_acks - a0), 32'd1);
        nextCycle();

        // DM write then read-back of the same word.
        c0 = cyc;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h1234_5678);
        waitNeg(c0 + 1);
        checkOutput("dmwr mem_en c1", 32'(mem_en), 32'd1);
        checkOutput("dmwr mem_we c1", 32'(mem_we), 32'd1);
        checkOutput("dmwr mem_addr c1", mem_addr, 32'h100);
        checkOutput("dmwr mem_wdata c1", mem_wdata, 32'h1234_5678);
        waitNeg(c0 + 4);
        checkOutput("dmwr dm_ack c4", 32'(dm_ack), 32'd1);
        checkOutput("dmwr dm_rdata c4", dm_rdata, 32'd0);
        nextCycle();
        c0 = cyc;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
        waitNeg(c0 + 4);
        checkOutput("dmrd dm_ack c4", 32'(dm_ack), 32'd1);
        checkOutput("dmrd dm_rdata c4", dm_rdata, 32'h1234_5678);
        nextCycle();
        dm_req = 1'b0;
        repeat (2) nextCycle();

        // Contention: both rise together, DM first, IF at the following IDLE.
        c0 = cyc;
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0);
        waitNeg(c0 + 4);
        checkOutput("cont dm_ack c4", 32'(dm_ack), 32'd1);
        checkOutput("cont if_ack c4", 32'(if_ack), 32'd0);
        nextCycle();
        dm_req = 1'b0;
        waitNeg(c0 + 6);
        checkOutput("cont mem_en c6", 32'(mem_en), 32'd1);
        checkOutput("cont mem_addr c6", mem_addr, 32'h40);
        waitNeg(c0 + 9);
        checkOutput("cont if_ack c9", 32'(if_ack), 32'd1);
        checkOutput("cont if_rdata c9", if_rdata, 32'hDEAD_BEEF);
        nextCycle();
        if_req = 1'b0;
        repeat (2) nextCycle();

        // Reset landing in the first WAIT cycle of an IF read.
        c0 = cyc;
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        waitNeg(c0 + 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        if_req = 1'b0;
        #1;
        checkOutput("rstw mem_en", 32'(mem_en), 32'd0);
        checkOutput("rstw if_ack", 32'(if_ack), 32'd0);
        checkOutput("rstw busy", 32'(busy), 32'd0);
        checkOutput("rstw mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        a0 = if_acks;
        waitNeg(cyc + 6);
        checkOutput("rstw no ack", 32'(if_acks - a0), 32'd0);
        checkOutput("rstw idle", 32'(busy), 32'd0);
        nextCycle();

        // Both requests held: observe the grant order from the strobe address.
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0);
        got = 0;
        order_dm = '0;
        for (int n = 0; n < 80 && got < 6; n++) begin
            @(negedge clk);
            if (mem_en) begin
                order_dm[got] = (mem_addr == 32'h100);
                got++;
            end
        end
        nextCycle();
        if_req = 1'b0;
        dm_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        exp_order = 6'b101111;
`else
        exp_order = 6'b111111;
`endif
        checkOutput("starve grant count", 32'(got), 32'd6);
        checkOutput("starve grant order", 32'(order_dm), 32'(exp_order));
        repeat (8) nextCycle();

        // Randomized traffic with requesters that hold until their modelled ack.
        if_pend = 0;
        dm_pend = 0;
        repeat (3000) begin
            nextCycle();
            if (m_if_done) if_pend = 0;
            if (m_dm_done) dm_pend = 0;
            if (!if_pend) begin
                if_addr = $urandom;
                if ($urandom_range(0, 2) == 0) begin
                    if_pend = 1;
                    if_addr = pick_addr();
                end
            end
            if (!dm_pend) begin
                dm_addr  = $urandom;
                dm_we    = 1'($urandom_range(0, 1));
                dm_wdata = $urandom;
                if ($urandom_range(0, 2) == 0) begin
                    dm_pend = 1;
                    dm_addr = pick_addr();
                end
            end
            if_req = if_pend;
            dm_req = dm_pend;
        end
        repeat (12) begin
            nextCycle();
            if (m_if_done) if_pend = 0;
            if (m_dm_done) dm_pend = 0;
            if_req = if_pend;
            dm_req = dm_pend;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        repeat (4) nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported synchronous memory between the processor's instruction-fetch port (IF) and data-memory port (DM). Each requester holds a level request until it receives a one-cycle ack. The block sequences every access through issue, wait and ack phases, and sits between the processor core and the unified memory model.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MEM_LATENCY, 2, cycles from the mem_en cycle to valid mem_rdata (legal range 1..15)
STARVE_LIMIT, 4, consecutive DM grants with IF pending before IF is forced (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  IF request, held until if_ack
if_addr  in  ADDR_W  IF read address
if_ack  out  1  one-cycle IF completion pulse
if_rdata  out  DATA_W  IF read data, valid while if_ack=1
dm_req  in  1  DM request, held until dm_ack
dm_we  in  1  DM write enable (1=write, 0=read)
dm_addr  in  ADDR_W  DM address
dm_wdata  in  DATA_W  DM write data
dm_ack  out  1  one-cycle DM completion pulse
dm_rdata  out  DATA_W  DM read data, valid while dm_ack=1
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE. if_ack, dm_ack, mem_en, mem_we and busy are 0. All data/address outputs are 0. The wait counter is 0 and any grant is cleared. An in-flight access is abandoned and no ack is issued for it.
- States: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
- IDLE: arbitration is sampled on the clock edge.
  - dm_req=1 wins (fixed DM priority).
  - Otherwise if_req=1 wins.
  - Otherwise stay in IDLE.
  - The winner's address, wdata and we are registered into mem_* and grant is latched; next state is ISSUE.
- ISSUE, exactly 1 cycle: mem_en=1, with mem_we = latched we for DM and 0 for IF. The wait counter loads MEM_LATENCY-1. Next state is WAIT.
- WAIT, exactly MEM_LATENCY cycles: mem_en=0. On the edge ending the final WAIT cycle, mem_rdata is captured into the granted port's rdata register. Next state is ACK.
- ACK, 1 cycle: the granted port's ack=1 and its rdata is driven. The other port's ack=0. Next state is IDLE.
- Latency: req sampled in cycle 0 -> mem_en in cycle 1 -> ack in cycle MEM_LATENCY+2. Back-to-back throughput is one access per MEM_LATENCY+3 cycles.
- The requester drops or changes req on the edge ending its ack cycle. Because IDLE follows ACK, the completed request is never re-granted.
- Writes: dm_rdata=0 during the write's ack.
- Non-granted rdata holds its last value and is not valid.
- Request inputs are ignored outside IDLE. A req that drops before ack is a protocol violation; the transaction still completes and ack still pulses.
- Both requests high in IDLE: DM is granted and IF waits. IF is granted at the next IDLE if dm_req=0 there.
- mem_addr, mem_wdata and mem_we hold stable from ISSUE through ACK.

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined: a 4-bit starve counter increments on each DM grant made while if_req=1. It clears on any IF grant, and on any arbitration where if_req=0. When the counter equals STARVE_LIMIT and both requests are high, IF is granted instead of DM.
- Undefined: no counter is built and DM priority is strict.

Test Plan:
- Reset mid-WAIT: assert rst in the first WAIT cycle of an IF read -> mem_en, if_ack and busy are 0 immediately. After release, state is IDLE and no if_ack is produced for the abandoned access.
- IF read, MEM_LATENCY=2: if_req=1, if_addr=0x40, memory returns 0xDEADBEEF -> mem_en=1 with mem_addr=0x40 in cycle 1. if_ack=1 with if_rdata=0xDEADBEEF in cycle 4, then busy=0 in cycle 5.
- DM write: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0x12345678 -> one mem_en cycle with mem_we=1 and the same addr/data. dm_ack in cycle 4 with dm_rdata=0. A subsequent DM read of 0x100 returns 0x12345678.
- Contention: if_req and dm_req both rise in cycle 0 -> dm_ack in cycle 4. IF mem_en in cycle 6 and if_ack in cycle 9.
- Held req: IF holds req through ack and drops it the following cycle -> exactly one mem_en and one if_ack.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT=4, both reqs continuously high -> grant order DM,DM,DM,DM,IF,DM. Without the macro, the order is DM only.
